// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared types and constants for the UART transmit/receive blocks.
// Contents: FSM state enum, default bit period for 100 MHz / 115200 baud,
// and the data width of one serial character.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read side plus serial line of the UART transmitter, bundled as one interface.
// Signals: fifo_rd_d / fifo_rd_empty (FIFO head and registered empty flag),
// fifo_rd_en (one-cycle pop strobe), txd (serial line, idle high), busy (frame in progress).
// Modports: master = FIFO/host side, slave = transmitter.
interface uart_tx_fifo_drain_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] fifo_rd_d;
    logic                 fifo_rd_empty;
    logic                 fifo_rd_en;
    logic                 txd;
    logic                 busy;

    modport master (
        output fifo_rd_d,
        output fifo_rd_empty,
        input  fifo_rd_en,
        input  txd,
        input  busy
    );

    modport slave (
        input  fifo_rd_d,
        input  fifo_rd_empty,
        output fifo_rd_en,
        output txd,
        output busy
    );

endinterface

// File: rtl/uart_tx_fifo_drain_baud_gen.sv
// Baud tick generator: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Ports: clk, rst (sync, active-high), clear (hold counter at 0), bit_end (combinational pulse).
// Latency: bit_end asserts CLKS_PER_BIT-1 cycles after clear drops; no backpressure.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    assign bit_end = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a registered-output byte FIFO into 8N1 frames (LSB first).
// Ports: clk, rst (sync, active-high), bus (uart_tx_fifo_drain_if.slave: FIFO read side, txd, busy).
// Latency: txd goes low the cycle after the pop; one pop per frame, only from IDLE, never when empty.
// Optional: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_fifo_drain_if.slave   bus
);

    localparam int                 BCW      = $clog2(DATA_BITS);
    localparam logic [BCW-1:0]     LAST_BIT = BCW'(DATA_BITS - 1);

    uart_state_t            r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [BCW-1:0]         r_bit_cnt;
    logic                   r_txd;
    logic                   r_busy;
`ifdef UART_TX_PARITY_EN
    logic                   r_parity;
`endif

    logic w_pop;
    logic w_bit_end;
    logic w_baud_clear;

    // Pop straight out of IDLE; rst gates it so nothing is consumed while held in reset.
    assign w_pop        = !rst && (r_state == IDLE) && !bus.fifo_rd_empty;
    // Holding the counter at 0 in IDLE makes the start bit begin on a fresh count.
    assign w_baud_clear = (r_state == IDLE);

    assign bus.fifo_rd_en = w_pop;
    assign bus.txd        = r_txd;
    assign bus.busy       = r_busy;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_baud_clear),
        .bit_end (w_bit_end)
    );

    // txd/busy are loaded with the level of the state being entered, so the line
    // changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state   <= START;
                        r_shift   <= bus.fifo_rd_d;
                        r_bit_cnt <= '0;
                        r_txd     <= 1'b0;
                        r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        // Taken from the captured byte; the shift register is consumed during DATA.
                        r_parity  <= ^bus.fifo_rd_d;
`endif
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_txd   <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                        if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_txd   <= r_parity;
`else
                            r_state <= STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_txd <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_txd   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_state <= IDLE;
                        r_txd   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench for uart_tx_fifo_drain with CLKS_PER_BIT=4.
// A queue-based FIFO drives the read side; frames are decoded from txd by mid-bit sampling
// and compared against the bytes pushed, in order.
module tb_uart_tx_fifo_drain;
    import uart_pkg::*;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_fifo_drain_if bus ();

    uart_tx_fifo_drain #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] fifo_q[$];   // FIFO contents seen by the DUT
    logic [7:0] model_q[$];  // bytes expected on the line, in order
    int         cyc      = 0;
    int         pop_cnt  = 0;
    int         pop_cyc[$];

    // Registered-output FIFO: contents update once per cycle, pop decided just before the edge.
    initial begin : fifo_model
        logic popped;
        popped = 1'b0;
        bus.fifo_rd_empty = 1'b1;
        bus.fifo_rd_d     = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
            bus.fifo_rd_empty = (fifo_q.size() == 0);
            if (fifo_q.size() > 0) bus.fifo_rd_d = fifo_q[0];
            else                   bus.fifo_rd_d = 8'h00;
            #4;
            popped = bus.fifo_rd_en;
            if (popped) begin
                pop_cnt++;
                pop_cyc.push_back(cyc);
                checks++;
                if (bus.fifo_rd_empty !== 1'b0) begin
                    failures++;
                    $display("FAIL pop_when_empty: fifo_rd_en=1 with fifo_rd_empty=%b at cycle %0d", bus.fifo_rd_empty, cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        model_q.push_back(b);
    endtask

    // Expected line level for frame bit position pos (0 = start).
    function automatic logic exp_level(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
`ifdef UART_TX_PARITY_EN
        if (pos == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wait_pop(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.fifo_rd_en === 1'b1) begin
                ok = 1'b1;
                return;
            end
            step();
        end
        checks++;
        failures++;
        $display("FAIL wait_pop: no fifo_rd_en within 200 cycles");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (bus.busy === 1'b0 && bus.txd === 1'b1) return;
            step();
        end
        checks++;
        failures++;
        $display("FAIL wait_idle: busy=%b txd=%b after 200 cycles", bus.busy, bus.txd);
    endtask

    task automatic decode_frame(output logic [7:0] d, output logic par, output logic stp);
        int off;
        bit found;
        d = 8'h00; par = 1'b0; stp = 1'b0; found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (bus.txd === 1'b0) found = 1'b1;
            else step();
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL decode_start: no start bit within 400 cycles");
            return;
        end
        off = 0;
        for (int k = 0; k < 8; k++) begin
            while (off < CPB*(k+1) + CPB/2) begin step(); off++; end
            d[k] = bus.txd;
        end
`ifdef UART_TX_PARITY_EN
        while (off < CPB*9 + CPB/2) begin step(); off++; end
        par = bus.txd;
`endif
        while (off < CPB*(FRAME_BITS-1) + CPB/2) begin step(); off++; end
        stp = bus.txd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b want 1", bus.txd); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            checks++;
            if ({bus.txd, bus.busy, bus.fifo_rd_en} !== 3'b100) begin
                failures++;
                $display("FAIL idle_empty: cycle %0d txd/busy/rd_en=%b want 100", i, {bus.txd, bus.busy, bus.fifo_rd_en});
            end
        end
    endtask

    task automatic test_single(input logic [7:0] b);
        int  p0;
        int  busy_cyc;
        bit  ok;
        logic el;
        p0 = pop_cnt;
        busy_cyc = 0;
        push(b);
        wait_pop(ok);
        if (!ok) return;
        void'(model_q.pop_front());
        for (int i = 1; i <= FRAME_CYC; i++) begin
            step();
            el = exp_level(b, (i-1)/CPB);
            if (bus.busy === 1'b1) busy_cyc++;
            checks++;
            if (bus.txd !== el) begin
                failures++;
                $display("FAIL single_txd: byte %02h cycle %0d got %b want %b", b, i, bus.txd, el);
            end
        end
        checks++;
        if (busy_cyc != FRAME_CYC) begin failures++; $display("FAIL single_busy_len: got %0d want %0d", busy_cyc, FRAME_CYC); end
        step();
        checks++;
        if ({bus.busy, bus.txd} !== 2'b01) begin
            failures++;
            $display("FAIL single_end: busy/txd=%b want 01", {bus.busy, bus.txd});
        end
        repeat (10) step();
        checks++;
        if (pop_cnt != p0 + 1) begin failures++; $display("FAIL single_pops: got %0d want %0d", pop_cnt - p0, 1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, e;
        logic par, stp;
        int   p0;
        p0 = pop_cyc.size();
        push(8'h00); push(8'hFF); push(8'h55);
        for (int f = 0; f < 3; f++) begin
            decode_frame(d, par, stp);
            e = model_q.pop_front();
            checks++;
            if (d !== e) begin failures++; $display("FAIL b2b_data: frame %0d got %02h want %02h", f, d, e); end
            checks++;
            if (stp !== 1'b1) begin failures++; $display("FAIL b2b_stop: frame %0d got %b want 1", f, stp); end
`ifdef UART_TX_PARITY_EN
            checks++;
            if (par !== ^e) begin failures++; $display("FAIL b2b_parity: frame %0d got %b want %b", f, par, ^e); end
`endif
        end
        wait_idle();
        checks++;
        if (pop_cyc.size() != p0 + 3) begin
            failures++;
            $display("FAIL b2b_pops: got %0d want 3", pop_cyc.size() - p0);
        end else begin
            for (int f = 1; f < 3; f++) begin
                checks++;
                if (pop_cyc[p0+f] - pop_cyc[p0+f-1] != FRAME_CYC + 1) begin
                    failures++;
                    $display("FAIL b2b_spacing: got %0d want %0d", pop_cyc[p0+f] - pop_cyc[p0+f-1], FRAME_CYC + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d, e;
        logic par, stp;
        int   p0;
        bit   ok;
        p0 = pop_cnt;
        push(8'h3C); push(8'h81);
        wait_pop(ok);
        if (!ok) return;
        repeat (18) step();  // inside data bit 3 of 0x3C
        checks++;
        if (bus.txd !== 1'b1) begin failures++; $display("FAIL rstmid_bit3: got %b want 1", bus.txd); end
        rst = 1'b1;
        void'(model_q.pop_front());  // byte in flight is lost by the reset
        step();
        checks++;
        if ({bus.txd, bus.busy} !== 2'b10) begin
            failures++;
            $display("FAIL rstmid_abort: txd/busy=%b want 10", {bus.txd, bus.busy});
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rstmid_rd_en: cycle %0d got %b want 0", i, bus.fifo_rd_en); end
            step();
        end
        checks++;
        if (pop_cnt != p0 + 1) begin failures++; $display("FAIL rstmid_pops_in_rst: got %0d want 1", pop_cnt - p0); end
        rst = 1'b0;
        decode_frame(d, par, stp);
        e = model_q.pop_front();
        checks++;
        if (d !== e) begin failures++; $display("FAIL rstmid_next: got %02h want %02h", d, e); end
        wait_idle();
        checks++;
        if (pop_cnt != p0 + 2) begin failures++; $display("FAIL rstmid_pops: got %0d want 2", pop_cnt - p0); end
    endtask

    task automatic test_empty_last();
        logic [7:0] d, e;
        logic par, stp;
        int   p0;
        p0 = pop_cnt;
        push(8'h5A);
        decode_frame(d, par, stp);
        e = model_q.pop_front();
        checks++;
        if (d !== e) begin failures++; $display("FAIL last_data: got %02h want %02h", d, e); end
        wait_idle();
        repeat (30) step();
        checks++;
        if (pop_cnt != p0 + 1) begin failures++; $display("FAIL last_pops: got %0d want 1", pop_cnt - p0); end
        checks++;
        if ({bus.txd, bus.busy} !== 2'b10) begin failures++; $display("FAIL last_idle: txd/busy=%b want 10", {bus.txd, bus.busy}); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            automatic logic [7:0] a   = 8'($urandom);
            automatic logic [7:0] b   = 8'($urandom);
            automatic int         dly = $urandom_range(0, 60);
            automatic logic [7:0] d0, d1, e;
            automatic logic       p0, p1, s0, s1;
            push(a);
            fork
                begin
                    repeat (dly) step();
                    push(b);
                end
                begin
                    decode_frame(d0, p0, s0);
                    decode_frame(d1, p1, s1);
                end
            join
            e = model_q.pop_front();
            checks++;
            if (d0 !== e || s0 !== 1'b1) begin failures++; $display("FAIL rand_a: round %0d got %02h/stop %b want %02h/1", r, d0, s0, e); end
`ifdef UART_TX_PARITY_EN
            checks++;
            if (p0 !== ^e) begin failures++; $display("FAIL rand_a_par: got %b want %b", p0, ^e); end
`endif
            e = model_q.pop_front();
            checks++;
            if (d1 !== e || s1 !== 1'b1) begin failures++; $display("FAIL rand_b: round %0d dly %0d got %02h/stop %b want %02h/1", r, dly, d1, s1, e); end
`ifdef UART_TX_PARITY_EN
            checks++;
            if (p1 !== ^e) begin failures++; $display("FAIL rand_b_par: got %b want %b", p1, ^e); end
`endif
            wait_idle();
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int busy_cyc;
        bit ok;
        logic par_seen;
        busy_cyc = 0;
        par_seen = 1'b0;
        push(8'h07);
        wait_pop(ok);
        if (!ok) return;
        void'(model_q.pop_front());
        for (int i = 1; i <= 60; i++) begin
            step();
            if (i == 9*CPB + 2) par_seen = bus.txd;
            if (bus.busy !== 1'b1) break;
            busy_cyc++;
        end
        checks++;
        if (par_seen !== 1'b1) begin failures++; $display("FAIL parity_bit: got %b want 1", par_seen); end
        checks++;
        if (busy_cyc != 11*CPB) begin failures++; $display("FAIL parity_len: got %0d want %0d", busy_cyc, 11*CPB); end
        wait_idle();
    endtask
`endif

    initial begin : main
        test_reset();
        test_single(8'hA5);
        test_back_to_back();
        test_reset_mid();
        test_empty_last();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
